seq_alu: RTL
============

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 4; operand and result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request; sampled on rising clk when busy=0.
REQ-005 sel  input  3  operation select, sampled with start.
REQ-006 a  input  WIDTH  operand A, sampled with start.
REQ-007 b  input  WIDTH  operand B, sampled with start.
REQ-008 cin  input  1  carry-in / shift-in, sampled with start.
REQ-009 F  output  WIDTH  registered result (low half for MUL).
REQ-010 hi  output  WIDTH  registered high half of MUL product; 0 for all other ops.
REQ-011 cout  output  1  registered carry / shifted-out bit.
REQ-012 ovf  output  1  registered signed overflow (ADD/SUB only, else 0).
REQ-013 zero  output  1  registered; 1 when F==0 and hi==0.
REQ-014 busy  output  1  high while a MUL is in progress.
REQ-015 done  output  1  one-cycle pulse; result outputs valid and stable from this cycle until the next completed op.

Function
REQ-016 Sel encoding: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 MUL, 111 SHR.
REQ-017 ADD: {cout,F} = a + b + cin, WIDTH+1-bit sum.
REQ-018 SUB: {cout,F} = a + ~b + cin; cin=1 gives a-b; cout=1 means no borrow.
REQ-019 ovf for ADD/SUB = 1 when both effective operands share a sign bit differing from F[WIDTH-1].
REQ-020 AND/OR/XOR: bitwise on a,b; cout=0.
REQ-021 SHL: F = {a[WIDTH-2:0],cin}, cout = a[WIDTH-1]; SHR: F = {cin,a[WIDTH-1:1]}, cout = a[0].
REQ-022 MUL: unsigned {hi,F} = a*b, computed by iterative shift-add, one partial step per clock; cin ignored; cout=0.
REQ-023 FSM states: IDLE, MUL_RUN; reset state IDLE.
REQ-024 IDLE, start=1, sel!=110: result, cout, ovf, zero registered at that same edge; done=1 next cycle; stay IDLE (latency 1).
REQ-025 IDLE, start=1, sel=110: latch a, b; clear accumulator; go MUL_RUN; busy=1 from next cycle; count=0.
REQ-026 MUL_RUN: each edge performs one step; after exactly WIDTH steps write {hi,F}, zero; go IDLE; busy=0 and done=1 in same cycle (latency WIDTH from start edge).
REQ-027 start while busy=1 is ignored; no queueing; operands not re-sampled.
REQ-028 Back-to-back: start may be asserted in the done cycle and is accepted.
REQ-029 Outputs F, hi, cout, ovf, zero hold their values when no op completes; intermediate MUL partials never appear on F/hi.
REQ-030 Counter width ceil(log2(WIDTH+1)); no wrap beyond WIDTH steps.

Reset
REQ-031 rst_n=0 asynchronously forces: F=0, hi=0, cout=0, ovf=0, zero=0, busy=0, done=0, state IDLE, counter 0, accumulator 0.
REQ-032 Reset mid-MUL aborts the op; no done pulse and no result written after release.
REQ-033 First start accepted on first rising edge with rst_n=1 and start=1.

Verification (WIDTH=4)
REQ-034 ADD a=F b=1 cin=0 -> next cycle F=0, cout=1, zero=1, ovf=0, done=1.
REQ-035 ADD a=7 b=1 cin=0 -> F=8, ovf=1, cout=0; SUB a=5 b=3 cin=1 -> F=2, cout=1, ovf=0.
REQ-036 SHL a=9 cin=1 -> F=3, cout=1; SHR a=9 cin=0 -> F=4, cout=1.
REQ-037 MUL a=F b=F -> busy=1 for 4 cycles, then {hi,F}=E1, done=1 exactly once, busy=0.
REQ-038 During MUL a=3 b=5, pulse start with ADD -> ignored; result {hi,F}=0F; single done.
REQ-039 Drop rst_n two cycles into MUL -> all outputs 0 immediately; after release no done until new start.

Source files
------------

// File: rtl/seq_alu_if.sv
// Request/result bundle for seq_alu. The master drives an op request;
// the slave returns the registered result plus busy/done status.
interface seq_alu_if #(
  parameter int WIDTH = 4
);
  // Handshake: start is honoured only on a rising edge where busy=0. The
  // result fields are valid from the cycle done pulses and hold until the
  // next completed op; a start while busy=1 is dropped, not queued.
  logic             start;
  logic [2:0]       sel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] F;
  logic [WIDTH-1:0] hi;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             busy;
  logic             done;
  logic             state_dbg;

  modport master (
    output start, sel, a, b, cin,
    input  F, hi, cout, ovf, zero, busy, done, state_dbg
  );

  modport slave (
    input  start, sel, a, b, cin,
    output F, hi, cout, ovf, zero, busy, done, state_dbg
  );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle add/sub/logic/shift ops and a multi-cycle
// shift-add unsigned multiply producing a double-width {hi,F} product.
module seq_alu #(
  parameter int WIDTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  seq_alu_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  typedef enum logic {
    IDLE    = 1'b0,
    MUL_RUN = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;

  logic [WIDTH-1:0] f_q;
  logic [WIDTH-1:0] hi_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;
  logic             done_q;

  logic             accept;
  logic             is_mul;
  logic             last_step;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_f;
  logic             alu_c;
  logic             alu_v;

  logic [WIDTH:0]   step_sum;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  assign accept    = (state == IDLE) && bus.start;
  assign is_mul    = (bus.sel == OP_MUL);
  assign last_step = (state == MUL_RUN) && (count == CW'(WIDTH - 1));

  // Single-cycle operations, evaluated straight from the request inputs.
  always_comb begin
    b_eff = bus.b;
    sum   = '0;
    alu_f = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (bus.sel)
      OP_ADD, OP_SUB: begin
        b_eff = (bus.sel == OP_SUB) ? ~bus.b : bus.b;
        sum   = {1'b0, bus.a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, bus.cin};
        alu_f = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (bus.a[WIDTH-1] == b_eff[WIDTH-1]) &&
                (alu_f[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND: alu_f = bus.a & bus.b;
      OP_OR:  alu_f = bus.a | bus.b;
      OP_XOR: alu_f = bus.a ^ bus.b;
      OP_SHL: begin
        alu_f = {bus.a[WIDTH-2:0], bus.cin};
        alu_c = bus.a[WIDTH-1];
      end
      OP_SHR: begin
        alu_f = {bus.cin, bus.a[WIDTH-1:1]};
        alu_c = bus.a[0];
      end
      default: ;
    endcase
  end

  // One right-shifting shift-add step: the multiplier sits in acc_lo and is
  // consumed LSB first while product bits shift in from the top.
  always_comb begin
    step_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    step_hi  = step_sum[WIDTH:1];
    step_lo  = {step_sum[0], acc_lo[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && is_mul) state_nxt = MUL_RUN;
      MUL_RUN: if (last_step)        state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      f_q    <= '0;
      hi_q   <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept && !is_mul) begin
        f_q    <= alu_f;
        hi_q   <= '0;
        cout_q <= alu_c;
        ovf_q  <= alu_v;
        zero_q <= (alu_f == '0);
        done_q <= 1'b1;
      end else if (accept && is_mul) begin
        mcand  <= bus.a;
        acc_hi <= '0;
        acc_lo <= bus.b;
        count  <= '0;
      end else if (state == MUL_RUN) begin
        acc_hi <= step_hi;
        acc_lo <= step_lo;
        // Partials stay internal; only the final step touches the outputs.
        if (last_step) begin
          f_q    <= step_lo;
          hi_q   <= step_hi;
          cout_q <= 1'b0;
          ovf_q  <= 1'b0;
          zero_q <= (step_lo == '0) && (step_hi == '0);
          done_q <= 1'b1;
          count  <= '0;
        end else begin
          count  <= count + CW'(1);
        end
      end
    end
  end

  assign bus.F         = f_q;
  assign bus.hi        = hi_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state == MUL_RUN);
  assign bus.state_dbg = state;

endmodule
